alu_ctrl_seq: RTL and testbench

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

---
 rtl/alu_ctrl_seq.sv | 170 +++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq -- sequencer between a RISC-V decode stage and an external
// combinational ALU. Accepts one decoded instruction at a time and drives
// operands/function to the ALU. It captures the ALU result and zero flag,
// then holds the outcome until the consumer takes it.
//   clk, rst_n (async, active low)
//   instr_valid/instr_ready         : instruction handshake
//   opcode, funct3, funct7b5        : decoded instruction fields
//   rs1_val, rs2_val, imm           : source operands, sign-extended immediate
//   ALUop1, ALUop2, ALUctrl         : registered ALU inputs
//   ALUOut, zero_i                  : ALU result and zero flag (combinational)
//   res_valid/res_ready             : result handshake
//   result, branch_taken, illegal   : outcome, held while res_valid=1
// Optional feature: define ALU_CTRL_BNE_EN to support BNE (branch funct3 001).
module alu_ctrl_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic [DATA_WIDTH-1:0] rs1_val,
  input  logic [DATA_WIDTH-1:0] rs2_val,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic [DATA_WIDTH-1:0] ALUop1,
  output logic [DATA_WIDTH-1:0] ALUop2,
  output logic [2:0]            ALUctrl,
  input  logic [DATA_WIDTH-1:0] ALUOut,
  input  logic                  zero_i,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  branch_taken,
  output logic                  illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd5;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  // How EXEC turns the zero flag into branch_taken.
  typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE} br_e;

  state_e                state_q, state_d;
  br_e                   br_q, br_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d, result_q, result_d;
  logic [2:0]            ctrl_q, ctrl_d;
  logic                  taken_q, taken_d, illegal_q, illegal_d;

  // Decode of the presented instruction.
  logic       dec_legal, dec_use_imm;
  logic [2:0] dec_ctrl;
  br_e        dec_br;

  always_comb begin
    dec_legal   = 1'b1;
    dec_use_imm = 1'b0;
    dec_ctrl    = ALU_ADD;
    dec_br      = BR_NONE;
    case (opcode)
      OP_R, OP_I: begin
        dec_use_imm = (opcode == OP_I);
        case (funct3)
          3'b000:  dec_ctrl = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  dec_ctrl = ALU_AND;
          3'b110:  dec_ctrl = ALU_OR;
          3'b010:  dec_ctrl = ALU_SLT;
          default: dec_legal = 1'b0;
        endcase
      end
      OP_LOAD, OP_STORE: dec_use_imm = 1'b1;
      OP_BRANCH: begin
        dec_ctrl = ALU_SUB;
        case (funct3)
          3'b000:  dec_br = BR_EQ;
`ifdef ALU_CTRL_BNE_EN
          3'b001:  dec_br = BR_NE;
`endif
          default: dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    br_d      = br_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    ctrl_d    = ctrl_q;
    result_d  = result_q;
    taken_d   = taken_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          if (dec_legal) begin
            op1_d     = rs1_val;
            op2_d     = dec_use_imm ? imm : rs2_val;
            ctrl_d    = dec_ctrl;
            br_d      = dec_br;
            illegal_d = 1'b0;
            state_d   = EXEC;
          end else begin
            // Unsupported: report immediately, leave ALU inputs untouched.
            illegal_d = 1'b1;
            result_d  = '0;
            taken_d   = 1'b0;
            state_d   = DONE;
          end
        end
      end
      EXEC: begin
        result_d = ALUOut;
        case (br_q)
          BR_EQ:   taken_d = zero_i;
          BR_NE:   taken_d = ~zero_i;
          default: taken_d = 1'b0;
        endcase
        state_d = DONE;
      end
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      br_q      <= BR_NONE;
      op1_q     <= '0;
      op2_q     <= '0;
      ctrl_q    <= ALU_ADD;
      result_q  <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      br_q      <= br_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      ctrl_q    <= ctrl_d;
      result_q  <= result_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  assign instr_ready  = (state_q == IDLE);
  assign res_valid    = (state_q == DONE);
  assign ALUop1       = op1_q;
  assign ALUop2       = op2_q;
  assign ALUctrl      = ctrl_q;
  assign result       = result_q;
  assign branch_taken = taken_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
module tb_alu_ctrl_seq;
  localparam int W = 32;

  logic         clk, rst_n, instr_valid, instr_ready, funct7b5, zero_i;
  logic         res_valid, res_ready, branch_taken, illegal;
  logic [6:0]   opcode;
  logic [2:0]   funct3, ALUctrl;
  logic [W-1:0] rs1_val, rs2_val, imm, ALUop1, ALUop2, ALUOut, result;

  int checks = 0;
  int errors = 0;

  alu_ctrl_seq #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl),
    .ALUOut(ALUOut), .zero_i(zero_i),
    .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .branch_taken(branch_taken), .illegal(illegal)
  );

  // External ALU the block drives.
  always_comb begin
    case (ALUctrl)
      3'd0:    ALUOut = ALUop1 + ALUop2;
      3'd1:    ALUOut = ALUop1 - ALUop2;
      3'd2:    ALUOut = ALUop1 & ALUop2;
      3'd3:    ALUOut = ALUop1 | ALUop2;
      3'd5:    ALUOut = {31'd0, $signed(ALUop1) < $signed(ALUop2)};
      default: ALUOut = '0;
    endcase
  end
  assign zero_i = (ALUOut == '0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drives one instruction through accept/exec/done with res_ready=1,
  // checking timing and outcome.
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] im, input logic [W-1:0] e_res, input logic e_br,
                           input logic e_ill, input logic [2:0] e_ctrl, input logic [W-1:0] e_op2);
    chk({tag, ".ready_idle"}, {31'd0, instr_ready}, 1);
    opcode = op; funct3 = f3; funct7b5 = f7;
    rs1_val = a; rs2_val = b; imm = im;
    instr_valid = 1'b1; res_ready = 1'b1;
    tick();
    instr_valid = 1'b0;
    if (!e_ill) begin
      chk({tag, ".exec_valid"}, {31'd0, res_valid}, 0);
      chk({tag, ".exec_ready"}, {31'd0, instr_ready}, 0);
      chk({tag, ".exec_ctrl"}, {29'd0, ALUctrl}, {29'd0, e_ctrl});
      chk({tag, ".exec_op1"}, ALUop1, a);
      chk({tag, ".exec_op2"}, ALUop2, e_op2);
      tick();
    end
    chk({tag, ".valid"}, {31'd0, res_valid}, 1);
    chk({tag, ".result"}, result, e_res);
    chk({tag, ".taken"}, {31'd0, branch_taken}, {31'd0, e_br});
    chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, e_ill});
    chk({tag, ".ctrl"}, {29'd0, ALUctrl}, {29'd0, e_ctrl});
    tick();
    chk({tag, ".released"}, {31'd0, res_valid}, 0);
  endtask

  // Reference model straight from the instruction semantics.
  task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] im,
                       inout logic [2:0] ctrl, output logic [W-1:0] res, output logic br,
                       output logic ill, output logic [W-1:0] o2);
    logic bne_ok;
`ifdef ALU_CTRL_BNE_EN
    bne_ok = 1'b1;
`else
    bne_ok = 1'b0;
`endif
    res = '0; br = 1'b0; ill = 1'b0;
    o2 = (op == 7'b0110011 || op == 7'b1100011) ? b : im;
    if (op == 7'b0110011 || op == 7'b0010011) begin
      if (f3 == 3'b000 && op == 7'b0110011 && f7) begin res = a - o2; ctrl = 1; end
      else if (f3 == 3'b000) begin res = a + o2; ctrl = 0; end
      else if (f3 == 3'b111) begin res = a & o2; ctrl = 2; end
      else if (f3 == 3'b110) begin res = a | o2; ctrl = 3; end
      else if (f3 == 3'b010) begin res = ($signed(a) < $signed(o2)) ? 1 : 0; ctrl = 5; end
      else ill = 1'b1;
    end else if (op == 7'b0000011 || op == 7'b0100011) begin
      res = a + im; ctrl = 0;
    end else if (op == 7'b1100011 && (f3 == 3'b000 || (f3 == 3'b001 && bne_ok))) begin
      res = a - b; ctrl = 1;
      br = (f3 == 3'b000) ? (a == b) : (a != b);
    end else ill = 1'b1;
  endtask

  typedef struct {
    string      tag;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [W-1:0] a, b, im, e_res;
    logic       e_br, e_ill;
    logic [2:0] e_ctrl;
    logic [W-1:0] e_op2;
  } vec_t;

  vec_t vecs[13];
  logic [2:0] mctrl;
  logic [W-1:0] m_res, m_op2;
  logic m_br, m_ill;
  logic [6:0] ops[7];

  initial begin
    vecs[0]  = '{"add",   7'b0110011, 3'b000, 1'b0, 5, 7, 0, 12, 0, 0, 0, 7};
    vecs[1]  = '{"sub",   7'b0110011, 3'b000, 1'b1, 3, 3, 0, 0, 0, 0, 1, 3};
    vecs[2]  = '{"beq_t", 7'b1100011, 3'b000, 1'b0, 3, 3, 0, 0, 1, 0, 1, 3};
`ifdef ALU_CTRL_BNE_EN
    vecs[3]  = '{"bne",   7'b1100011, 3'b001, 1'b0, 4, 9, 0, 32'hFFFF_FFFB, 1, 0, 1, 9};
`else
    vecs[3]  = '{"bne",   7'b1100011, 3'b001, 1'b0, 4, 9, 0, 0, 0, 1, 1, 9};
`endif
    vecs[4]  = '{"addi",  7'b0010011, 3'b000, 1'b1, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'hFFFF_FFFF};
    vecs[5]  = '{"and",   7'b0110011, 3'b111, 1'b0, 32'hF0F0, 32'hFF00, 0, 32'hF000, 0, 0, 2, 32'hFF00};
    vecs[6]  = '{"ori",   7'b0010011, 3'b110, 1'b0, 32'h0F, 0, 32'h30, 32'h3F, 0, 0, 3, 32'h30};
    vecs[7]  = '{"slt",   7'b0110011, 3'b010, 1'b0, 32'hFFFF_FFFF, 1, 0, 1, 0, 0, 5, 1};
    vecs[8]  = '{"slti",  7'b0010011, 3'b010, 1'b0, 5, 0, 32'hFFFF_FFFD, 0, 0, 0, 5, 32'hFFFF_FFFD};
    vecs[9]  = '{"sw",    7'b0100011, 3'b010, 1'b0, 32'h200, 0, 4, 32'h204, 0, 0, 0, 4};
    vecs[10] = '{"lui",   7'b0110111, 3'b000, 1'b0, 1, 2, 3, 0, 0, 1, 0, 0};
    vecs[11] = '{"sll",   7'b0110011, 3'b001, 1'b0, 1, 2, 0, 0, 0, 1, 0, 0};
    vecs[12] = '{"beq_n", 7'b1100011, 3'b000, 1'b0, 4, 9, 0, 32'hFFFF_FFFB, 0, 0, 1, 9};
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b1101111};

    rst_n = 1'b0; instr_valid = 1'b0; res_ready = 1'b0;
    opcode = '0; funct3 = '0; funct7b5 = 1'b0; rs1_val = '0; rs2_val = '0; imm = '0;
    #2;
    chk("rst.ready", {31'd0, instr_ready}, 1);
    chk("rst.valid", {31'd0, res_valid}, 0);
    chk("rst.result", result, 0);
    chk("rst.ctrl", {29'd0, ALUctrl}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++)
      run_instr(vecs[i].tag, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b,
                vecs[i].im, vecs[i].e_res, vecs[i].e_br, vecs[i].e_ill, vecs[i].e_ctrl,
                vecs[i].e_op2);

    // Random instructions against the reference model.
    mctrl = 3'd1;
    for (int i = 0; i < 200; i++) begin
      logic [6:0] op; logic [2:0] f3; logic f7; logic [W-1:0] a, b, im;
      op = ops[$urandom_range(0, 6)];
      f3 = 3'($urandom_range(0, 7));
      f7 = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      im = $urandom;
      model(op, f3, f7, a, b, im, mctrl, m_res, m_br, m_ill, m_op2);
      run_instr("rand", op, f3, f7, a, b, im, m_res, m_br, m_ill, mctrl, m_op2);
    end

    // ADDI held in DONE with res_ready low; a second instruction must be ignored.
    opcode = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b0;
    rs1_val = 1; imm = 32'hFFFF_FFFF; instr_valid = 1'b1; res_ready = 1'b0;
    tick();
    opcode = 7'b0110011; rs1_val = 5; rs2_val = 7;
    chk("hold.op2", ALUop2, 32'hFFFF_FFFF);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold.valid", {31'd0, res_valid}, 1);
      chk("hold.result", result, 0);
      chk("hold.ready", {31'd0, instr_ready}, 0);
      tick();
    end
    instr_valid = 1'b0; res_ready = 1'b1;
    tick();
    chk("hold.idle", {31'd0, instr_ready}, 1);
    chk("hold.noaccept", {31'd0, res_valid}, 0);
    tick();
    chk("hold.noaccept2", {31'd0, res_valid}, 0);

    // Reset during EXEC of ORI (previous result/ctrl are nonzero).
    run_instr("pre", 7'b0110011, 3'b110, 1'b0, 32'h11, 32'h22, 0, 32'h33, 0, 0, 3, 32'h22);
    opcode = 7'b0010011; funct3 = 3'b110; rs1_val = 32'h0F; imm = 32'h30; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst.ready", {31'd0, instr_ready}, 1);
    chk("arst.valid", {31'd0, res_valid}, 0);
    chk("arst.result", result, 0);
    chk("arst.taken", {31'd0, branch_taken}, 0);
    chk("arst.illegal", {31'd0, illegal}, 0);
    chk("arst.op1", ALUop1, 0);
    chk("arst.op2", ALUop2, 0);
    chk("arst.ctrl", {29'd0, ALUctrl}, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst.novalid", {31'd0, res_valid}, 0);
    end
    run_instr("lw", 7'b0000011, 3'b010, 1'b0, 32'h100, 0, 8, 32'h108, 0, 0, 0, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
